cnn_mem_loader: RTL and testbench
=================================

# cnn_mem_loader

Avalon-MM bus initiator for the CNN memory peripheral. Weight and image bytes from an upstream byte stream are written into a selected region as a burst of single-byte writes. Result bytes are read back from the output buffer into a downstream byte stream. The block sits between the HPS-side DMA/FIFO logic and the peripheral's chipselect/write/read/address/writedata slave port, so software no longer issues each byte by hand.

## Interface
- ADDR_W, 19, bus address width
- LEN_W, 18, command length width in bytes (largest region 230400)
- RD_LATENCY, 1, cycles from accepted read to valid readdata (1..3)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_op  in  1  0 = write region, 1 = read output buffer
- cmd_region  in  3  write target 0..4 (input, L1, L2, L3, L4); ignored for reads
- cmd_len  in  LEN_W  byte count
- s_valid / s_ready  in/out  1  write-source byte stream handshake
- s_data  in  8  write-source byte
- m_valid / m_ready  out/in  1  readback byte stream handshake
- m_data  out  8  readback byte
- chipselect, write, read  out  1  bus strobes
- address  out  ADDR_W  bus address
- writedata  out  8  bus write byte
- readdata  in  8  bus read byte
- waitrequest  in  1  slave stall
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse, coincident with done, on a rejected command
- csum  out  16  byte checksum of the last command

## Operation
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, RD_OUT, FIN.
- IDLE: cmd_ready=1. On accept, latch op/region/len, clear the index, and go to WR or RD_REQ.
- Reject with err, no bus activity, and go to FIN in these cases:
  - region > 4 on a write
  - cmd_len > 16384 on a read
  - cmd_len = 0 (done without err)
- WR:
  - s_ready = !pending || !waitrequest.
  - An accepted byte drives chipselect=1, write=1, address=region, writedata=byte on the next cycle.
  - The transaction is held unchanged while waitrequest=1.
  - The pending write retires on the cycle with write && !waitrequest.
  - After len retirements, go to FIN. The slave auto-increments internally, so address stays constant.
- RD_REQ: drive chipselect=1, read=1, address=index. Hold while waitrequest=1. On acceptance, go to RD_WAIT.
- RD_WAIT: count RD_LATENCY cycles, capture readdata into a one-entry buffer, then go to RD_OUT.
- RD_OUT:
  - m_valid=1 with the buffered byte.
  - On m_ready, increment the index. Go to FIN if index = len, else RD_REQ.
  - At most one read is outstanding.
- FIN: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Index and counters are LEN_W wide, unsigned. There is no wrap; the len bound is checked before each increment.

## Timing
- Reset values: cmd_ready=0 during reset, then 1. All other outputs are 0: s_ready, m_valid, m_data, chipselect, write, read, address, writedata, busy, done, err, csum.
- Write path:
  - Byte accepted at cycle k appears on the bus at k+1.
  - Throughput is 1 byte/cycle with waitrequest=0.
  - done is asserted the cycle after the last retirement.
- Read path:
  - Read accepted at cycle r; readdata is sampled at r+RD_LATENCY.
  - m_valid is asserted at r+RD_LATENCY+1.
  - The next read issues the cycle after the m handshake.
- Strobes never change while waitrequest=1, except on reset.
- Reset mid-command: all strobes drop at the next edge and the FSM returns to IDLE. Partial data is discarded. Software must also reset the peripheral, because its region counters are not rewound.
- A command presented together with done is not accepted until IDLE (the cycle after FIN).

## Configuration
- CNN_MEM_LOADER_CSUM_EN:
  - Defined: csum is the mod-2^16 sum of every byte retired on the bus (writes) or handed off on m (reads). It is cleared at command accept and is stable from done until the next accept.
  - Undefined: csum is tied to 0 and the adder is not synthesized.

## Structure
- Package cnn_pkg holds:
  - the region enum (REG_INPUT=0, REG_L1..REG_L4=1..4)
  - localparams for region sizes (10000, 400, 12800, 230400, 10600) and OUT_SIZE=16384
  - ADDR_W and the state typedef
- Sub-module cnn_rd_buf is natural: a one-entry readback holding register with the valid/ready handshake.

## Test plan
- Write: region 1, len 400, s_valid continuous, waitrequest=0 -> 400 write strobes on consecutive cycles, address=1, bytes in order; done 401 cycles after first accept; csum = byte sum mod 65536.
- Write with waitrequest=1 for 3 cycles on beat 5 -> the beat 5 transaction is held for 4 cycles; s_ready=0 during the stall; no byte is lost or duplicated.
- Read: len 4, RD_LATENCY=2, readdata = 0xA0+index, m_ready toggling -> addresses 0,1,2,3; m_data A0..A3; one read outstanding at most.
- Rejects:
  - write region 5 -> done+err pulse, no strobes
  - read len 20000 -> done+err pulse, no strobes
  - len 0 -> done without err
- Reset at write beat 100 of 10000 -> strobes 0 at the next edge, busy=0, cmd_ready=1; a new command then runs cleanly.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN memory loader: bus widths, region
// codes, region/output sizes, FSM state encoding and the command screen.
package cnn_pkg;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned LEN_W  = 18;

  localparam int unsigned SIZE_INPUT = 10000;
  localparam int unsigned SIZE_L1    = 400;
  localparam int unsigned SIZE_L2    = 12800;
  localparam int unsigned SIZE_L3    = 230400;
  localparam int unsigned SIZE_L4    = 10600;
  localparam int unsigned OUT_SIZE   = 16384;

  typedef enum logic [2:0] {
    REG_INPUT = 3'd0,
    REG_L1    = 3'd1,
    REG_L2    = 3'd2,
    REG_L3    = 3'd3,
    REG_L4    = 3'd4
  } region_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_OUT  = 3'd4,
    FIN     = 3'd5
  } state_e;

  // A write needs a real region; a read may not run past the output buffer.
  function automatic logic cmd_rejected(input logic op, input logic [2:0] region,
                                        input logic [LEN_W-1:0] len);
    logic bad;
    if (op) begin
      bad = (len > LEN_W'(OUT_SIZE));
    end else begin
      bad = (region > 3'(REG_L4));
    end
    return bad;
  endfunction

endpackage

// File: rtl/cnn_mem_loader_if.sv
// Command, byte-stream, Avalon-MM and status signals of the CNN memory loader.
interface cnn_mem_loader_if;
  import cnn_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [2:0]        cmd_region;
  logic [LEN_W-1:0]  cmd_len;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              m_valid;
  logic              m_ready;
  logic [7:0]        m_data;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [7:0]        writedata;
  logic [7:0]        readdata;
  logic              waitrequest;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       csum;

  modport master (
    input  cmd_valid, cmd_op, cmd_region, cmd_len, s_valid, s_data, m_ready,
           readdata, waitrequest,
    output cmd_ready, s_ready, m_valid, m_data, chipselect, write, read,
           address, writedata, busy, done, err, csum
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_region, cmd_len, s_valid, s_data, m_ready,
           readdata, waitrequest,
    input  cmd_ready, s_ready, m_valid, m_data, chipselect, write, read,
           address, writedata, busy, done, err, csum
  );

endinterface

// File: rtl/cnn_rd_buf.sv
// One-entry readback holding register: loaded from the bus, drained by the
// downstream valid/ready handshake.
module cnn_rd_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  // Next-state for the holding register.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cnn_mem_loader.sv
// Avalon-MM initiator moving byte streams into CNN regions and reading the
// output buffer back. CNN_MEM_LOADER_CSUM_EN enables the per-command byte checksum.
module cnn_mem_loader
  import cnn_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  cnn_mem_loader_if.master bus
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY);

  state_e            state_q, state_d;
  logic [2:0]        region_q, region_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d, acc_q, acc_d;
  logic              cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [1:0]        lat_q, lat_d;
  logic              cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic              done_q, done_d, err_q, err_d;

  logic             cmd_acc, cmd_bad, cmd_empty, last;
  logic [LEN_W-1:0] idx_inc;
  logic             s_rdy, s_acc, wr_ret, rd_acc, rd_cap, m_hs;
  logic             m_valid;
  logic [7:0]       m_data;

  assign cmd_acc   = bus.cmd_valid && cmd_ready_q;
  assign cmd_bad   = cmd_rejected(bus.cmd_op, bus.cmd_region, bus.cmd_len);
  assign cmd_empty = (bus.cmd_len == LEN_W'(0));
  assign idx_inc   = idx_q + LEN_W'(1);
  assign last      = (idx_inc == len_q);
  // A new byte may be taken once the pending write retires in this cycle.
  assign s_rdy     = !reset && (state_q == WR) && (acc_q != len_q) &&
                     (!wr_q || !bus.waitrequest);
  assign s_acc     = s_rdy && bus.s_valid;
  assign wr_ret    = wr_q && !bus.waitrequest;
  assign rd_acc    = rd_q && !bus.waitrequest;
  assign rd_cap    = (state_q == RD_WAIT) && (lat_q == LAT_LAST);
  assign m_hs      = m_valid && bus.m_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!cmd_acc)                 state_d = IDLE;
        else if (cmd_bad || cmd_empty) state_d = FIN;
        else if (bus.cmd_op)          state_d = RD_REQ;
        else                          state_d = WR;
      end
      WR:      if (wr_ret && last) state_d = FIN;     else state_d = WR;
      RD_REQ:  if (rd_acc)         state_d = RD_WAIT; else state_d = RD_REQ;
      RD_WAIT: if (rd_cap)         state_d = RD_OUT;  else state_d = RD_WAIT;
      RD_OUT: begin
        if (!m_hs)     state_d = RD_OUT;
        else if (last) state_d = FIN;
        else           state_d = RD_REQ;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    region_d = region_q; len_d = len_q; idx_d = idx_q; acc_d = acc_q;
    cs_d = cs_q; wr_d = wr_q; rd_d = rd_q; addr_d = addr_q; wdata_d = wdata_q;
    lat_d = lat_q;
    err_d       = 1'b0;
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          region_d = bus.cmd_region;
          len_d    = bus.cmd_len;
          idx_d    = LEN_W'(0);
          acc_d    = LEN_W'(0);
          err_d    = cmd_bad;
          if (!cmd_bad && !cmd_empty && bus.cmd_op) begin
            cs_d   = 1'b1;
            rd_d   = 1'b1;
            addr_d = ADDR_W'(0);
          end else begin
            rd_d = 1'b0;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      WR: begin
        if (s_acc) begin
          acc_d   = acc_q + LEN_W'(1);
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = ADDR_W'(region_q);
          wdata_d = bus.s_data;
        end else if (wr_ret) begin
          cs_d = 1'b0;
          wr_d = 1'b0;
        end else begin
          wr_d = wr_q;
        end
        if (wr_ret) idx_d = idx_inc; else idx_d = idx_q;
      end
      RD_REQ: begin
        if (rd_acc) begin
          cs_d  = 1'b0;
          rd_d  = 1'b0;
          lat_d = 2'd1;
        end else begin
          rd_d = rd_q;
        end
      end
      RD_WAIT: begin
        if (rd_cap) lat_d = 2'd0; else lat_d = lat_q + 2'd1;
      end
      RD_OUT: begin
        if (m_hs) begin
          idx_d = idx_inc;
          if (!last) begin
            cs_d   = 1'b1;
            rd_d   = 1'b1;
            addr_d = ADDR_W'(idx_inc);
          end else begin
            rd_d = 1'b0;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      FIN: begin
        cs_d = 1'b0;
        wr_d = 1'b0;
        rd_d = 1'b0;
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      region_q <= 3'd0; len_q <= LEN_W'(0); idx_q <= LEN_W'(0); acc_q <= LEN_W'(0);
      cs_q <= 1'b0; wr_q <= 1'b0; rd_q <= 1'b0;
      addr_q <= ADDR_W'(0); wdata_q <= 8'h00; lat_q <= 2'd0;
      cmd_ready_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      region_q <= region_d; len_q <= len_d; idx_q <= idx_d; acc_q <= acc_d;
      cs_q <= cs_d; wr_q <= wr_d; rd_q <= rd_d;
      addr_q <= addr_d; wdata_q <= wdata_d; lat_q <= lat_d;
      cmd_ready_q <= cmd_ready_d; busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
    end
  end

  cnn_rd_buf u_rd_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (rd_cap),
    .data_i  (bus.readdata),
    .ready_i (bus.m_ready),
    .valid_o (m_valid),
    .data_o  (m_data)
  );

`ifdef CNN_MEM_LOADER_CSUM_EN
  logic [15:0] csum_q, csum_d;

  // Checksum accumulates retired writes or delivered readback bytes.
  always_comb begin
    csum_d = csum_q;
    if (cmd_acc)     csum_d = 16'h0000;
    else if (wr_ret) csum_d = csum_q + {8'h00, wdata_q};
    else if (m_hs)   csum_d = csum_q + {8'h00, m_data};
    else             csum_d = csum_q;
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (reset) csum_q <= 16'h0000;
    else       csum_q <= csum_d;
  end

  assign bus.csum = csum_q;
`else
  assign bus.csum = 16'h0000;
`endif

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.s_ready    = s_rdy;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = m_data;
  assign bus.chipselect = cs_q;
  assign bus.write      = wr_q;
  assign bus.read       = rd_q;
  assign bus.address    = addr_q;
  assign bus.writedata  = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_cnn_mem_loader.sv
// Directed bench for cnn_mem_loader: writes, stalled write, latency-2 reads,
// rejects, zero length and mid-command reset.
module tb_cnn_mem_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnn_mem_loader_if bus ();

  cnn_mem_loader #(.RD_LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef CNN_MEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [15:0] sum_pat(input int n);
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < n; i++) s = s + {8'h00, pat(i)};
    return s;
  endfunction

  int done_cyc, err_at_done, err_wo_done, nret, wr_cycles, first_wr, order_err;
  int stall_hold, srdy_stall, strobes, nrd, nhs, outst_max, first_mv, first_racc;
  logic [18:0] rd_addr [8];
  logic [7:0]  mdat    [8];

  task automatic run_cmd(input logic op, input logic [2:0] region, input logic [17:0] len,
                         input int stall_beat, input int abort_ret, input int budget);
    int cyc, sent, stall_left, pend_cyc, pend_addr, outst;
    bit hs_prev;
    done_cyc = -1; err_at_done = 0; err_wo_done = 0; nret = 0; wr_cycles = 0;
    first_wr = -1; order_err = 0; stall_hold = 0; srdy_stall = 0; strobes = 0;
    nrd = 0; nhs = 0; outst_max = 0; first_mv = -1; first_racc = -1;
    cyc = 0; sent = 0; stall_left = 3; pend_cyc = -10; pend_addr = 0; outst = 0; hs_prev = 1'b0;
    check("idle_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_region = region; bus.cmd_len = len;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    while (done_cyc < 0 && cyc < budget && !(abort_ret > 0 && nret >= abort_ret)) begin
      if (hs_prev) sent++;
      bus.s_valid  = !op && (sent < int'(len));
      bus.s_data   = pat(sent);
      bus.m_ready  = cyc[2];
      bus.readdata = (cyc == pend_cyc) ? 8'(8'hA0 + pend_addr) : 8'h55;
      bus.waitrequest = 1'b0;
      if (bus.write && nret == stall_beat && stall_left > 0) begin
        bus.waitrequest = 1'b1;
        stall_left--;
      end
      #1;
      if (bus.done) begin done_cyc = cyc; err_at_done = bus.err; end
      if (bus.err && !bus.done) err_wo_done++;
      if (bus.chipselect || bus.write || bus.read) strobes++;
      if (bus.write) begin
        wr_cycles++;
        if (first_wr < 0) first_wr = cyc;
        if (bus.writedata != pat(nret) || bus.address != 19'(region)) order_err++;
        if (nret == stall_beat) stall_hold++;
        if (bus.waitrequest && bus.s_ready) srdy_stall++;
        if (!bus.waitrequest) nret++;
      end
      if (bus.read && !bus.waitrequest) begin
        if (nrd < 8) rd_addr[nrd] = bus.address;
        if (first_racc < 0) first_racc = cyc;
        nrd++; outst++;
        pend_cyc = cyc + 2; pend_addr = int'(bus.address);
      end
      if (bus.m_valid) begin
        if (first_mv < 0) first_mv = cyc;
        if (bus.m_ready) begin
          if (nhs < 8) mdat[nhs] = bus.m_data;
          nhs++; outst--;
        end
      end
      if (outst > outst_max) outst_max = outst;
      hs_prev = bus.s_ready && bus.s_valid;
      @(posedge clk); #1;
      cyc++;
    end
    bus.s_valid = 1'b0; bus.m_ready = 1'b0; bus.waitrequest = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_region = 3'd0; bus.cmd_len = 18'd0;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.m_ready = 1'b0;
    bus.readdata = 8'h00; bus.waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {bus.cmd_ready, bus.s_ready, bus.m_valid, bus.chipselect, bus.write,
                        bus.read, bus.busy, bus.done, bus.err}, 0);
    check("rst_bus", {bus.address, bus.writedata}, 0);
    check("rst_m_csum", {bus.m_data, bus.csum}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", bus.cmd_ready, 1);

    // Continuous write of region L1.
    run_cmd(1'b0, 3'd1, 18'd400, -1, 0, 600);
    check("w400_nret", nret, 400);
    check("w400_wr_cycles", wr_cycles, 400);
    check("w400_first_wr", first_wr, 1);
    check("w400_done_cyc", done_cyc, 401);
    check("w400_err", err_at_done, 0);
    check("w400_order", order_err, 0);
    check("w400_csum", bus.csum, CSUM_EN ? sum_pat(400) : 16'h0000);
    check("w400_busy_idle", bus.busy, 0);

    // Beat 5 stalled three cycles.
    run_cmd(1'b0, 3'd0, 18'd10, 5, 0, 100);
    check("stall_hold", stall_hold, 4);
    check("stall_s_ready", srdy_stall, 0);
    check("stall_nret", nret, 10);
    check("stall_wr_cycles", wr_cycles, 13);
    check("stall_done_cyc", done_cyc, 14);
    check("stall_order", order_err, 0);
    check("stall_csum", bus.csum, CSUM_EN ? sum_pat(10) : 16'h0000);

    // Read 4 bytes, latency 2, m_ready = cyc[2].
    run_cmd(1'b1, 3'd0, 18'd4, -1, 0, 100);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd_addr%0d", i), rd_addr[i], i);
      check($sformatf("rd_data%0d", i), mdat[i], 8'hA0 + i);
    end
    check("rd_nreads", nrd, 4);
    check("rd_outstanding", outst_max, 1);
    check("rd_mvalid_lat", first_mv - first_racc, 3);
    check("rd_done_cyc", done_cyc, 29);
    check("rd_err", err_at_done, 0);
    check("rd_csum", bus.csum, CSUM_EN ? 16'h0286 : 16'h0000);

    // Rejects and zero length.
    run_cmd(1'b0, 3'd5, 18'd10, -1, 0, 20);
    check("rej_reg_done", done_cyc, 0);
    check("rej_reg_err", err_at_done, 1);
    check("rej_reg_strobes", strobes, 0);
    run_cmd(1'b1, 3'd0, 18'd20000, -1, 0, 20);
    check("rej_len_done", done_cyc, 0);
    check("rej_len_err", err_at_done, 1);
    check("rej_len_strobes", strobes, 0);
    run_cmd(1'b0, 3'd1, 18'd0, -1, 0, 20);
    check("len0_done", done_cyc, 0);
    check("len0_err", err_at_done, 0);
    check("len0_strobes", strobes + err_wo_done, 0);

    // Reset in the middle of a long write.
    run_cmd(1'b0, 3'd0, 18'd10000, -1, 100, 400);
    check("mid_nret", nret, 100);
    check("mid_write_on", bus.write, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_strobes", {bus.chipselect, bus.write, bus.read}, 0);
    check("mid_rst_busy", bus.busy, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ready", bus.cmd_ready, 1);
    run_cmd(1'b0, 3'd2, 18'd8, -1, 0, 50);
    check("post_nret", nret, 8);
    check("post_done_cyc", done_cyc, 9);
    check("post_order", order_err, 0);
    check("post_csum", bus.csum, CSUM_EN ? sum_pat(8) : 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
